// File: rtl/label_seq_ctrl.sv
// Label memory sequencer for LSTM backprop: walks label addresses, streams labels out.
// Optional REVERSE_ORDER_EN walks iterations and steps from last to first (BPTT order).
module label_seq_ctrl #(
  parameter int WIDTH          = 32,
  parameter int NUM            = 8,
  parameter int NUM_ITERATIONS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic        [WIDTH-1:0] mem_addr,
  input  logic signed [WIDTH-1:0] mem_data,
  output logic signed [WIDTH-1:0] label,
  output logic                    label_valid,
  input  logic                    label_ready,
  output logic        [WIDTH-1:0] iter,
  output logic        [WIDTH-1:0] step,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, LOAD, VALID, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_MAX = WIDTH'(NUM - 1);
  localparam logic [WIDTH-1:0] ITER_MAX = WIDTH'(NUM_ITERATIONS - 1);
  localparam logic [WIDTH-1:0] ADDR_MAX = WIDTH'(NUM * NUM_ITERATIONS - 1);

`ifdef REVERSE_ORDER_EN
  localparam logic [WIDTH-1:0] ITER_FIRST = ITER_MAX;
  localparam logic [WIDTH-1:0] STEP_FIRST = STEP_MAX;
  localparam logic [WIDTH-1:0] ADDR_FIRST = ADDR_MAX;
  localparam logic [WIDTH-1:0] ITER_LAST  = '0;
  localparam logic [WIDTH-1:0] STEP_LAST  = '0;
`else
  localparam logic [WIDTH-1:0] ITER_FIRST = '0;
  localparam logic [WIDTH-1:0] STEP_FIRST = '0;
  localparam logic [WIDTH-1:0] ADDR_FIRST = '0;
  localparam logic [WIDTH-1:0] ITER_LAST  = ITER_MAX;
  localparam logic [WIDTH-1:0] STEP_LAST  = STEP_MAX;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] iter_n, step_n, addr_n;
  logic             last_step, last_label;

  assign last_step  = (step == STEP_LAST);
  assign last_label = last_step && (iter == ITER_LAST);

  assign label_valid = (state == VALID);
  assign busy        = (state == LOAD) || (state == VALID);
  assign done        = (state == DONE);

  always_comb begin
    state_n = state;
    iter_n  = iter;
    step_n  = step;
    addr_n  = mem_addr;
    if (abort) begin
      state_n = IDLE;
      iter_n  = '0;
      step_n  = '0;
      addr_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = LOAD;
            iter_n  = ITER_FIRST;
            step_n  = STEP_FIRST;
            addr_n  = ADDR_FIRST;
          end
        end
        LOAD: state_n = VALID;
        VALID: begin
          if (label_ready) begin
            if (last_label) begin
              state_n = DONE;
            end else begin
              state_n = LOAD;
              // address is linear in (iter, step), so it just tracks by one
`ifdef REVERSE_ORDER_EN
              addr_n = mem_addr - ONE;
              if (last_step) begin
                step_n = STEP_MAX;
                iter_n = iter - ONE;
              end else begin
                step_n = step - ONE;
              end
`else
              addr_n = mem_addr + ONE;
              if (last_step) begin
                step_n = '0;
                iter_n = iter + ONE;
              end else begin
                step_n = step + ONE;
              end
`endif
            end
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iter     <= '0;
      step     <= '0;
      mem_addr <= '0;
      label    <= '0;
    end else begin
      state    <= state_n;
      iter     <= iter_n;
      step     <= step_n;
      mem_addr <= addr_n;
      if (state == LOAD && !abort)
        label <= mem_data;
    end
  end

endmodule
